branch_predict_track: RTL and testbench
=======================================

# branch_predict_track

Carries each fetched instruction's branch-prediction context (prediction bit, BHT index, PHT index) from Fetch through Decode and Execute to Memory, alongside the main pipeline registers. In Execute it compares the prediction against the resolved outcome and flags mispredictions to the hazard unit. In Memory it produces the one-shot training bundle (`branchM`, `BHT_indexM`, `PHT_indexM`, `takenM`) consumed by `branch_predict_local`.

## Interface
- `PHT_INDEX_BITS`, default 7: PHT index width; must equal the predictor's value.
- `BHT_INDEX_BITS`, default 3: BHT index width.
- `BHR_BITS`, default 4: history register width; must be < `PHT_INDEX_BITS`.
- `PC_TAIL`, default 2: lowest PC bit used in the PHT index.
- `clk` in 1: single clock; all state is rising-edge.
- `rst` in 1: asynchronous, active-low reset (already decided).
- `pcF` in 32: Fetch PC.
- `predict_takeF` in 1: predictor output for `pcF`.
- `BHRF` in `BHR_BITS`: history selected by the predictor for `pcF`.
- `stallD`/`stallE`/`stallM` in 1: hold the respective stage register.
- `flushD`/`flushE`/`flushM` in 1: invalidate the respective stage register.
- `branchD` in 1: Decode identifies a conditional branch.
- `actual_takenE` in 1: resolved branch direction in Execute.
- `predict_takeD`, `predict_takeE` out 1: carried prediction, for the datapath redirect mux.
- `mispredictE` out 1: combinational; valid branch in E whose prediction ≠ `actual_takenE`.
- `branchM` out 1: one-cycle training strobe.
- `BHT_indexM` out `BHT_INDEX_BITS`; `PHT_indexM` out `PHT_INDEX_BITS`; `takenM` out 1.
- `perf_branches`, `perf_mispredicts` out 32: only with `BP_PERF_CNT_EN`.

## Operation
- F indices: `bht_idxF = pcF[BHT_INDEX_BITS-1:0]`; `pht_idxF = {pcF[PC_TAIL+PHT_INDEX_BITS-BHR_BITS-1 : PC_TAIL], BHRF}`.
- Stage registers D, E, M each hold {valid, pred, bht_idx, pht_idx}; E and M also hold `is_branch`; M also holds `taken` and `done`.
- Per stage, each edge: flush → valid=0, other fields don't-care; else stall → hold; else load from the previous stage. Flush beats stall.
- D always loads with valid=1 (F is always valid). `is_branch` is captured from `branchD` when D→E.
- `mispredictE = validE & is_branchE & (predE ^ actual_takenE)`. Not registered, not self-flushing; the hazard unit drives the flushes.
- `actual_takenE` is captured into M `taken` when E→M.
- `done` clears on every M load and sets after the first cycle in which `branchM` was high.
- `branchM = validM & is_branchM & ~done`. A stalled M therefore trains the predictor exactly once.
- `BHT_indexM`, `PHT_indexM` and `takenM` are driven directly from M register fields.

## Timing
- Reset (async, while `rst`=0): all valid bits, `done`, all indices, predictions and counters = 0. Therefore `branchM`=0, `mispredictE`=0 and all outputs are 0.
- Reset release: the first rising edge loads D from F.
- Latency F→M is 3 edges with no stalls. `branchM` is high the cycle the branch sits in M.
- `mispredictE` is valid in the same cycle as `actual_takenE`.
- Simultaneous `stallM` and a new E entry: M holds; the E entry waits (the hazard unit also stalls E).
- `flushM` while `done`=0: no training strobe for that branch.

## Configuration
- `BP_PERF_CNT_EN` defined: two 32-bit counters.
  - `perf_branches` increments when `branchM`=1.
  - `perf_mispredicts` increments when `branchM`=1 and the M-stage prediction ≠ `takenM`.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Not defined: counter ports and logic are absent.

## Test plan
- Reset mid-run: assert `rst`=0 asynchronously between edges → all outputs read 0 immediately; no `branchM` on the next edge.
- No stalls: `pcF`=0x0000_0048, `BHRF`=4'b1010, `predict_takeF`=1, `branchD`=1, `actual_takenE`=0 →
  - `mispredictE`=1 at cycle 2;
  - at cycle 3: `branchM`=1, `BHT_indexM`=3'b000, `PHT_indexM`=7'b010_1010, `takenM`=0.
- Correct prediction: same as above with `actual_takenE`=1 → `mispredictE`=0, `takenM`=1.
- `stallM` held 4 cycles with a branch in M → `branchM` high for exactly 1 cycle; indices stable for all 4.
- `flushE` asserted together with `stallE` on a branch → E invalid next cycle; no `mispredictE`, no `branchM`.
- `BP_PERF_CNT_EN`: 5 branches with 2 mispredicted → `perf_branches`=5, `perf_mispredicts`=2. Preload 0xFFFF_FFFF → the counter stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_predict_track.sv
// ---------------------------------------------------------------------------
// branch_predict_track
//
// Carries the branch-prediction context of every fetched instruction
// (prediction bit, BHT index, PHT index) alongside the main pipeline through
// the Decode, Execute and Memory stage registers.
//   - Execute: compares the carried prediction with the resolved direction
//     and raises mispredictE (combinational) for the hazard unit.
//   - Memory: presents a one-shot training bundle (branchM, BHT_indexM,
//     PHT_indexM, takenM) for the local branch predictor. A stalled M stage
//     trains exactly once.
//
// Optional feature macro: BP_PERF_CNT_EN
//   When defined, adds two saturating 32-bit performance counters
//   (perf_branches, perf_mispredicts). When undefined, those ports and the
//   counter logic do not exist.
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active low
//   pcF, predict_takeF,    Fetch PC, predictor output and selected history
//   BHRF
//   stallD/E/M             hold the respective stage register
//   flushD/E/M             invalidate the respective stage register
//                          (flush has priority over stall)
//   branchD                Decode marks a conditional branch
//   actual_takenE          resolved branch direction in Execute
//   predict_takeD/E        carried prediction for the redirect mux
//   mispredictE            valid branch in E whose prediction was wrong
//   branchM                one-cycle training strobe
//   BHT_indexM, PHT_indexM training indices from the M stage
//   takenM                 resolved direction of the M-stage branch
//   perf_branches,         performance counters (BP_PERF_CNT_EN only)
//   perf_mispredicts
// ---------------------------------------------------------------------------
module branch_predict_track #(
    parameter int PHT_INDEX_BITS = 7,
    parameter int BHT_INDEX_BITS = 3,
    parameter int BHR_BITS       = 4,
    parameter int PC_TAIL        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pcF,
    input  logic                      predict_takeF,
    input  logic [BHR_BITS-1:0]       BHRF,
    input  logic                      stallD,
    input  logic                      stallE,
    input  logic                      stallM,
    input  logic                      flushD,
    input  logic                      flushE,
    input  logic                      flushM,
    input  logic                      branchD,
    input  logic                      actual_takenE,
    output logic                      predict_takeD,
    output logic                      predict_takeE,
    output logic                      mispredictE,
    output logic                      branchM,
    output logic [BHT_INDEX_BITS-1:0] BHT_indexM,
    output logic [PHT_INDEX_BITS-1:0] PHT_indexM,
    output logic                      takenM
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]               perf_branches,
    output logic [31:0]               perf_mispredicts
`endif
);

    localparam int PC_PART_BITS = PHT_INDEX_BITS - BHR_BITS;

    // -----------------------------------------------------------------------
    // Fetch-side index formation
    // -----------------------------------------------------------------------
    logic [BHT_INDEX_BITS-1:0] bht_idx_f;
    logic [PHT_INDEX_BITS-1:0] pht_idx_f;

    assign bht_idx_f = pcF[BHT_INDEX_BITS-1:0];
    // PHT index = selected PC slice above the instruction alignment bits,
    // concatenated with the local history of this branch.
    assign pht_idx_f = {pcF[PC_TAIL+PC_PART_BITS-1:PC_TAIL], BHRF};

    // Only a slice of the PC participates in the indices.
    logic unused_pc;
    assign unused_pc = ^pcF;

    // -----------------------------------------------------------------------
    // Decode stage register
    // -----------------------------------------------------------------------
    logic                      valid_d_reg;
    logic                      pred_d_reg;
    logic [BHT_INDEX_BITS-1:0] bht_d_reg;
    logic [PHT_INDEX_BITS-1:0] pht_d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_d_reg <= 1'b0;
            pred_d_reg  <= 1'b0;
            bht_d_reg   <= '0;
            pht_d_reg   <= '0;
        end else if (flushD) begin
            valid_d_reg <= 1'b0;
        end else if (!stallD) begin
            // Fetch always presents a valid instruction.
            valid_d_reg <= 1'b1;
            pred_d_reg  <= predict_takeF;
            bht_d_reg   <= bht_idx_f;
            pht_d_reg   <= pht_idx_f;
        end
    end

    // -----------------------------------------------------------------------
    // Execute stage register
    // -----------------------------------------------------------------------
    logic                      valid_e_reg;
    logic                      pred_e_reg;
    logic                      is_branch_e_reg;
    logic [BHT_INDEX_BITS-1:0] bht_e_reg;
    logic [PHT_INDEX_BITS-1:0] pht_e_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_e_reg     <= 1'b0;
            pred_e_reg      <= 1'b0;
            is_branch_e_reg <= 1'b0;
            bht_e_reg       <= '0;
            pht_e_reg       <= '0;
        end else if (flushE) begin
            valid_e_reg     <= 1'b0;
        end else if (!stallE) begin
            valid_e_reg     <= valid_d_reg;
            pred_e_reg      <= pred_d_reg;
            is_branch_e_reg <= branchD;
            bht_e_reg       <= bht_d_reg;
            pht_e_reg       <= pht_d_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Memory stage register
    // -----------------------------------------------------------------------
    logic                      valid_m_reg;
    logic                      pred_m_reg;
    logic                      is_branch_m_reg;
    logic                      taken_m_reg;
    logic                      done_m_reg;
    logic [BHT_INDEX_BITS-1:0] bht_m_reg;
    logic [PHT_INDEX_BITS-1:0] pht_m_reg;
    logic                      branch_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_m_reg     <= 1'b0;
            pred_m_reg      <= 1'b0;
            is_branch_m_reg <= 1'b0;
            taken_m_reg     <= 1'b0;
            done_m_reg      <= 1'b0;
            bht_m_reg       <= '0;
            pht_m_reg       <= '0;
        end else if (flushM) begin
            valid_m_reg     <= 1'b0;
            done_m_reg      <= 1'b0;
        end else if (!stallM) begin
            valid_m_reg     <= valid_e_reg;
            pred_m_reg      <= pred_e_reg;
            is_branch_m_reg <= is_branch_e_reg;
            taken_m_reg     <= actual_takenE;
            done_m_reg      <= 1'b0;
            bht_m_reg       <= bht_e_reg;
            pht_m_reg       <= pht_e_reg;
        end else if (branch_m) begin
            // Held branch has already trained once; suppress repeats.
            done_m_reg      <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign branch_m      = valid_m_reg & is_branch_m_reg & ~done_m_reg;
    assign branchM       = branch_m;
    assign mispredictE   = valid_e_reg & is_branch_e_reg & (pred_e_reg ^ actual_takenE);
    assign predict_takeD = pred_d_reg;
    assign predict_takeE = pred_e_reg;
    assign BHT_indexM    = bht_m_reg;
    assign PHT_indexM    = pht_m_reg;
    assign takenM        = taken_m_reg;

`ifdef BP_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Saturating performance counters, advanced by each training strobe
    // -----------------------------------------------------------------------
    logic [31:0] perf_branches_reg;
    logic [31:0] perf_mispredicts_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches_reg    <= '0;
            perf_mispredicts_reg <= '0;
        end else if (branch_m) begin
            if (perf_branches_reg != 32'hFFFF_FFFF) begin
                perf_branches_reg <= perf_branches_reg + 32'd1;
            end
            if ((pred_m_reg != taken_m_reg) && (perf_mispredicts_reg != 32'hFFFF_FFFF)) begin
                perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_reg;
    assign perf_mispredicts = perf_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predict_track.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_track
//
// Directed, self-checking bench for branch_predict_track. A table of
// single-instruction records is pushed through F->D->E->M and compared at
// E and M; hand-written sequences cover async reset mid-run, a stalled M
// stage, flush-over-stall in E and a flushed M stage.
// ---------------------------------------------------------------------------
module tb_branch_predict_track;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        predict_takeF;
    logic [3:0]  BHRF;
    logic        stallD, stallE, stallM;
    logic        flushD, flushE, flushM;
    logic        branchD;
    logic        actual_takenE;
    logic        predict_takeD, predict_takeE;
    logic        mispredictE;
    logic        branchM;
    logic [2:0]  BHT_indexM;
    logic [6:0]  PHT_indexM;
    logic        takenM;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    branch_predict_track dut (
        .clk           (clk),
        .rst           (rst),
        .pcF           (pcF),
        .predict_takeF (predict_takeF),
        .BHRF          (BHRF),
        .stallD        (stallD),
        .stallE        (stallE),
        .stallM        (stallM),
        .flushD        (flushD),
        .flushE        (flushE),
        .flushM        (flushM),
        .branchD       (branchD),
        .actual_takenE (actual_takenE),
        .predict_takeD (predict_takeD),
        .predict_takeE (predict_takeE),
        .mispredictE   (mispredictE),
        .branchM       (branchM),
        .BHT_indexM    (BHT_indexM),
        .PHT_indexM    (PHT_indexM),
        .takenM        (takenM)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  bhr;
        logic        pred;
        logic        br;
        logic        tk;
        logic        e_mis;
        logic        e_bm;
        logic [2:0]  e_bht;
        logic [6:0]  e_pht;
        logic        e_tk;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leave the task 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Push one instruction from F into E and present its resolved direction.
    task automatic launch(input logic [31:0] pc, input logic [3:0] bhr,
                          input logic pred, input logic br, input logic tk);
        pcF = pc; BHRF = bhr; predict_takeF = pred; branchD = 1'b0; actual_takenE = 1'b0;
        step();                          // D <= instruction
        settle();
        chk("predict_takeD", {31'd0, predict_takeD}, {31'd0, pred});
        pcF = 32'd0; BHRF = 4'd0; predict_takeF = 1'b0; branchD = br;
        step();                          // E <= instruction
        branchD = 1'b0; actual_takenE = tk;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_predD"}, {31'd0, predict_takeD}, 32'd0);
        chk({tag, "_predE"}, {31'd0, predict_takeE}, 32'd0);
        chk({tag, "_misE"},  {31'd0, mispredictE},   32'd0);
        chk({tag, "_brM"},   {31'd0, branchM},       32'd0);
        chk({tag, "_bhtM"},  {29'd0, BHT_indexM},    32'd0);
        chk({tag, "_phtM"},  {25'd0, PHT_indexM},    32'd0);
        chk({tag, "_tkM"},   {31'd0, takenM},        32'd0);
    endtask

    initial begin
        int bm_count;

        //          pc            bhr     pd  br  tk   mis bm  bht     pht          tkM
        vecs[0] = '{32'h0000_0048, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 7'b010_1010, 1'b0};
        vecs[1] = '{32'h0000_0048, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 7'b010_1010, 1'b1};
        vecs[2] = '{32'h0000_001C, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 7'b111_0011, 1'b1};
        vecs[3] = '{32'h0000_0035, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 7'b101_1111, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 7'b111_0000, 1'b0};

        rst = 1'b1;
        pcF = 32'd0; BHRF = 4'd0; predict_takeF = 1'b0;
        stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
        flushD = 1'b0; flushE = 1'b0; flushM = 1'b0;
        branchD = 1'b0; actual_takenE = 1'b0;

        // ---- power-on reset ----
        #1 rst = 1'b0;
        #1 chk_all_zero("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        $display("reset released");

        // ---- async reset mid-run with a mispredicting branch in E ----
        launch(32'h0000_001C, 4'h3, 1'b1, 1'b1, 1'b0);
        settle();
        chk("mid_pre_misE", {31'd0, mispredictE}, 32'd1);
        #1 rst = 1'b0;
        #1 chk_all_zero("mid");
        #1 rst = 1'b1;
        step();
        settle();
        chk("mid_post_brM", {31'd0, branchM}, 32'd0);
        chk("mid_post_misE", {31'd0, mispredictE}, 32'd0);
        $display("async reset mid-run: branchM=%0b mispredictE=%0b", branchM, mispredictE);

        // ---- table-driven vectors ----
        for (int i = 0; i < 5; i++) begin
            launch(vecs[i].pc, vecs[i].bhr, vecs[i].pred, vecs[i].br, vecs[i].tk);
            settle();
            chk($sformatf("v%0d_misE", i),  {31'd0, mispredictE},   {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_predE", i), {31'd0, predict_takeE}, {31'd0, vecs[i].pred});
            step();                      // M <= instruction
            actual_takenE = 1'b0;
            settle();
            chk($sformatf("v%0d_brM", i),  {31'd0, branchM},    {31'd0, vecs[i].e_bm});
            chk($sformatf("v%0d_bhtM", i), {29'd0, BHT_indexM}, {29'd0, vecs[i].e_bht});
            chk($sformatf("v%0d_phtM", i), {25'd0, PHT_indexM}, {25'd0, vecs[i].e_pht});
            chk($sformatf("v%0d_tkM", i),  {31'd0, takenM},     {31'd0, vecs[i].e_tk});
            if (vecs[i].e_bm) begin
                exp_br++;
                if (vecs[i].pred != vecs[i].tk) exp_mis++;
            end
            $display("vec %0d pc=0x%08h misE=%0b brM=%0b bht=%0d pht=0x%02h tkM=%0b",
                     i, vecs[i].pc, vecs[i].e_mis, branchM, BHT_indexM, PHT_indexM, takenM);
        end

        // ---- stallM held for 4 cycles with a branch in M ----
        launch(32'h0000_0048, 4'hA, 1'b1, 1'b1, 1'b0);
        step();                          // M <= branch
        actual_takenE = 1'b0;
        stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
        bm_count = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("stall%0d_brM", k), {31'd0, branchM}, (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("stall%0d_bhtM", k), {29'd0, BHT_indexM}, 32'd0);
            chk($sformatf("stall%0d_phtM", k), {25'd0, PHT_indexM}, 32'h2A);
            if (branchM) bm_count++;
            step();
        end
        stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
        settle();
        chk("stall_release_brM", {31'd0, branchM}, 32'd0);
        chk("stall_strobe_count", bm_count, 32'd1);
        exp_br++; exp_mis++;
        step();
        $display("stallM x4: branchM strobes=%0d", bm_count);

        // ---- flushE together with stallE while a branch moves D->E ----
        pcF = 32'h0000_0048; BHRF = 4'hA; predict_takeF = 1'b1; branchD = 1'b0;
        step();                          // D <= X1
        pcF = 32'h0000_001C; BHRF = 4'h3; predict_takeF = 1'b1; branchD = 1'b1;
        step();                          // E <= X1, D <= X2
        pcF = 32'd0; BHRF = 4'd0; predict_takeF = 1'b0;
        branchD = 1'b1; actual_takenE = 1'b0; flushE = 1'b1; stallE = 1'b1;
        settle();
        chk("fe_x1_misE", {31'd0, mispredictE}, 32'd1);
        step();                          // M <= X1, E flushed
        flushE = 1'b0; stallE = 1'b0; branchD = 1'b0;
        settle();
        chk("fe_misE", {31'd0, mispredictE}, 32'd0);
        chk("fe_x1_brM", {31'd0, branchM}, 32'd1);
        chk("fe_x1_phtM", {25'd0, PHT_indexM}, 32'h2A);
        exp_br++; exp_mis++;
        step();                          // M <= flushed E
        settle();
        chk("fe_x2_brM", {31'd0, branchM}, 32'd0);
        $display("flushE+stallE: misE=%0b brM=%0b", mispredictE, branchM);

        // ---- flushM while the branch enters M ----
        launch(32'h0000_001C, 4'h3, 1'b0, 1'b1, 1'b1);
        flushM = 1'b1;
        step();
        flushM = 1'b0; actual_takenE = 1'b0;
        settle();
        chk("fm_brM0", {31'd0, branchM}, 32'd0);
        step();
        settle();
        chk("fm_brM1", {31'd0, branchM}, 32'd0);
        $display("flushM: brM=%0b", branchM);

`ifdef BP_PERF_CNT_EN
        chk("perf_branches", perf_branches, exp_br);
        chk("perf_mispredicts", perf_mispredicts, exp_mis);
        $display("perf: branches=%0d mispredicts=%0d", perf_branches, perf_mispredicts);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
